// File: rtl/div_seq.sv
// Sequential restoring radix-2 unsigned 32/32 divider, one quotient bit per cycle.
// Optional DIV_SEQ_ZERO_FAST_EN: divide-by-zero completes in a single cycle.
`timescale 1ns/1ps
module div_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] b_q, b_d;
  logic [63:0] c_q, c_d;
  logic        done_q, done_d;

  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        neg;
  logic [32:0] rem_step;
  logic [31:0] quo_step;

  // quo_q starts as the dividend and shifts out into the remainder
  always_comb begin
    rem_sh   = {rem_q[31:0], quo_q[31]};
    trial    = rem_sh - {1'b0, b_q};
    neg      = trial[32];
    rem_step = neg ? rem_sh : trial;
    quo_step = {quo_q[30:0], ~neg};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    b_d     = b_q;
    c_d     = c_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          b_d   = b;
          quo_d = a;
          rem_d = '0;
          cnt_d = '0;
`ifdef DIV_SEQ_ZERO_FAST_EN
          if (b == 32'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            c_d     = {a, 32'hFFFF_FFFF};
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        if (!valid) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = DONE;
            done_d  = 1'b1;
            c_d     = {rem_step[31:0], quo_step};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign c    = c_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: latency, results, abort, reset, back-to-back.
// Divide-by-zero latency follows DIV_SEQ_ZERO_FAST_EN.
`timescale 1ns/1ps
module tb_div_seq;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [63:0] c;

  int n_vec = 0;
  int n_err = 0;

`ifdef DIV_SEQ_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  div_seq dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .a      (a),
    .b      (b),
    .done   (done),
    .c      (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; that cycle is T.
  task automatic run_op(input string tag, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] expc,
                        input int lat);
    logic [63:0] c0;
    int          seen_at;
    c0      = c;
    seen_at = -1;
    valid   = 1'b1;
    a       = av;
    b       = bv;
    @(negedge clk);
    chk({tag, "_idle_done"}, {63'd0, done}, 64'd0);
    for (int k = 1; k <= 40 && seen_at < 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin
        a = ~av;
        b = bv + 32'd7;
      end
      @(negedge clk);
      if (done) seen_at = k;
      else if (k == lat - 1) chk({tag, "_hold"}, c, c0);
    end
    chk({tag, "_lat"}, 64'(seen_at), 64'(lat));
    chk({tag, "_c"}, c, expc);
  endtask

  task automatic end_op(input string tag);
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, {63'd0, done}, 64'd0);
  endtask

  logic [63:0] c_keep;

  initial begin
    resetn = 1'b0;
    valid  = 1'b0;
    a      = '0;
    b      = '0;
    #12;
    chk("rst_c", c, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    @(posedge clk); #1;
    run_op("d100_7", 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    end_op("d100_7");

    @(posedge clk); #1;
    run_op("dmax_1", 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
    end_op("dmax_1");

    @(posedge clk); #1;
    run_op("d5_9", 32'd5, 32'd9, {32'd5, 32'd0}, 33);
    end_op("d5_9");

    @(posedge clk); #1;
    run_op("dzero", 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, ZLAT);
    end_op("dzero");

    // abort at T+10, idle through T+11, restart at T+12
    @(posedge clk); #1;
    c_keep = c;
    valid  = 1'b1;
    a      = 32'd100;
    b      = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    chk("abort_done_a", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_done_b", {63'd0, done}, 64'd0);
    chk("abort_c", c, c_keep);
    @(posedge clk); #1;
    run_op("restart", 32'd50, 32'd3, {32'd2, 32'd16}, 33);
    end_op("restart");

    // asynchronous reset mid-operation
    @(posedge clk); #1;
    valid = 1'b1;
    a     = 32'd1000;
    b     = 32'd3;
    repeat (20) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_c", c, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 32'd9, 32'd4, {32'd1, 32'd2}, 33);
    end_op("after_rst");

    // back-to-back with valid held: second done 34 cycles after first
    @(posedge clk); #1;
    run_op("b2b_1", 32'd1000, 32'd7, {32'd6, 32'd142}, 33);
    @(posedge clk); #1;
    run_op("b2b_2", 32'd123456, 32'd100, {32'd56, 32'd1234}, 33);
    end_op("b2b_2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
